// File: rtl/paxi_pkg.sv
// Shared packed-AXI definitions: burst encodings, access types and the
// legality rule for burst commands.
package paxi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic ATYPE_WRITE = 1'b1;
  localparam logic ATYPE_READ  = 1'b0;

  // WRAP needs a power-of-two beat count of 2..16; the reserved code is never legal.
  function automatic logic burst_illegal(input burst_e burst, input logic [7:0] len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (burst == BURST_RSVD) || ((burst == BURST_WRAP) && !wrap_len_ok);
  endfunction

endpackage

// File: rtl/paxi_beat_gen_if.sv
// Merged address command in, per-beat command out.
interface paxi_beat_gen_if #(parameter int ADDR_WIDTH = 32);
  logic [ADDR_WIDTH-1:0] paxi_aaddr;
  logic [7:0]            paxi_alen;
  logic [2:0]            paxi_asize;
  logic [1:0]            paxi_aburst;
  logic                  paxi_atype;
  logic                  paxi_avalid;
  logic                  paxi_aready;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic                  beat_type;
  logic [7:0]            beat_idx;
  logic                  beat_last;
  logic                  beat_valid;
  logic                  beat_ready;
  logic                  burst_err;

  modport master (
    output paxi_aaddr, paxi_alen, paxi_asize, paxi_aburst, paxi_atype, paxi_avalid, beat_ready,
    input  paxi_aready, beat_addr, beat_type, beat_idx, beat_last, beat_valid, burst_err
  );

  modport slave (
    input  paxi_aaddr, paxi_alen, paxi_asize, paxi_aburst, paxi_atype, paxi_avalid, beat_ready,
    output paxi_aready, beat_addr, beat_type, beat_idx, beat_last, beat_valid, burst_err
  );
endinterface

// File: rtl/paxi_next_addr.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
// Anything other than FIXED or WRAP advances as INCR.
module paxi_next_addr
  import paxi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  burst_e                burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] bytes, inc, tot, mask;

  assign bytes = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << size;
  assign inc   = addr + bytes;
  assign tot   = bytes * (ADDR_WIDTH'(len) + ADDR_WIDTH'(1));
  assign mask  = tot - ADDR_WIDTH'(1);

  always_comb begin
    next_addr = inc;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~mask) | (inc & mask);
      default:     next_addr = inc;
    endcase
  end

endmodule

// File: rtl/paxi_beat_gen.sv
// Expands one merged address command per handshake into len+1 beat commands,
// back to back with no bubble between bursts.
module paxi_beat_gen
  import paxi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rstn,
  paxi_beat_gen_if.slave bus
);

  logic [ADDR_WIDTH-1:0] beat_addr_q, beat_addr_d, next_addr;
  logic [7:0]            beat_idx_q, beat_idx_d, cmd_len_q, cmd_len_d;
  logic [2:0]            cmd_size_q, cmd_size_d;
  burst_e                cmd_burst_q, cmd_burst_d, in_burst;
  logic                  beat_last_q, beat_last_d;
  logic                  beat_type_q, beat_type_d;
  logic                  beat_valid_q, beat_valid_d;
  logic                  burst_err_q, burst_err_d;
  logic                  accept, illegal;

  // A new command may load on the same edge that retires the previous last beat.
  assign bus.paxi_aready = rstn & (~beat_valid_q | (bus.beat_ready & beat_last_q));
  assign accept          = bus.paxi_avalid & bus.paxi_aready;
  assign in_burst        = burst_e'(bus.paxi_aburst);
  assign illegal         = burst_illegal(in_burst, bus.paxi_alen);

  paxi_next_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_next_addr (
    .addr      (beat_addr_q),
    .size      (cmd_size_q),
    .len       (cmd_len_q),
    .burst     (cmd_burst_q),
    .next_addr (next_addr)
  );

  always_comb begin
    beat_addr_d  = beat_addr_q;
    beat_idx_d   = beat_idx_q;
    beat_last_d  = beat_last_q;
    beat_type_d  = beat_type_q;
    beat_valid_d = beat_valid_q;
    cmd_len_d    = cmd_len_q;
    cmd_size_d   = cmd_size_q;
    cmd_burst_d  = cmd_burst_q;
    burst_err_d  = 1'b0;
    if (accept) begin
      beat_addr_d  = bus.paxi_aaddr;
      beat_idx_d   = 8'd0;
      beat_last_d  = (bus.paxi_alen == 8'd0);
      beat_type_d  = bus.paxi_atype;
      beat_valid_d = 1'b1;
      cmd_len_d    = bus.paxi_alen;
      cmd_size_d   = bus.paxi_asize;
      cmd_burst_d  = illegal ? BURST_INCR : in_burst;
      burst_err_d  = illegal;
    end else if (beat_valid_q && bus.beat_ready) begin
      if (beat_last_q) begin
        beat_valid_d = 1'b0;
      end else begin
        beat_idx_d  = beat_idx_q + 8'd1;
        beat_addr_d = next_addr;
        beat_last_d = ((beat_idx_q + 8'd1) == cmd_len_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_addr_q  <= '0;
      beat_idx_q   <= '0;
      beat_last_q  <= 1'b0;
      beat_type_q  <= 1'b0;
      beat_valid_q <= 1'b0;
      cmd_len_q    <= '0;
      cmd_size_q   <= '0;
      cmd_burst_q  <= BURST_FIXED;
      burst_err_q  <= 1'b0;
    end else begin
      beat_addr_q  <= beat_addr_d;
      beat_idx_q   <= beat_idx_d;
      beat_last_q  <= beat_last_d;
      beat_type_q  <= beat_type_d;
      beat_valid_q <= beat_valid_d;
      cmd_len_q    <= cmd_len_d;
      cmd_size_q   <= cmd_size_d;
      cmd_burst_q  <= cmd_burst_d;
      burst_err_q  <= burst_err_d;
    end
  end

  assign bus.beat_addr  = beat_addr_q;
  assign bus.beat_idx   = beat_idx_q;
  assign bus.beat_last  = beat_last_q;
  assign bus.beat_type  = beat_type_q;
  assign bus.beat_valid = beat_valid_q;
  assign bus.burst_err  = burst_err_q;

endmodule

// File: tb/tb_paxi_beat_gen.sv
// Directed plus randomized bench; a queue of expected beats per accepted
// command is compared against the beat stream every cycle.
module tb_paxi_beat_gen;
  import paxi_pkg::*;

  localparam int AW = 32;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
    logic          typ;
  } cmd_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    idx;
    logic          last;
    logic          typ;
  } beat_t;

  logic clk, rstn;
  int   n_chk, n_fail;
  int   rdy_mode;
  bit   rdy_script[$];
  beat_t exp_q[$];
  logic  err_pend;

  paxi_beat_gen_if #(.ADDR_WIDTH(AW)) bus ();

  paxi_beat_gen #(.ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic illegal_cmd(input cmd_t c);
    if (c.burst == 2'b11) return 1'b1;
    if (c.burst == 2'b10) return !(c.len == 1 || c.len == 3 || c.len == 7 || c.len == 15);
    return 1'b0;
  endfunction

  // Address of beat i computed directly from the start address.
  function automatic logic [AW-1:0] addr_of(input cmd_t c, input int i);
    logic [AW-1:0] bytes, tot, base, ii;
    bytes = 32'd1 << c.size;
    ii    = i;
    if (c.burst == 2'b00) return c.addr;
    if (c.burst == 2'b10 && !illegal_cmd(c)) begin
      tot  = bytes * (32'(c.len) + 32'd1);
      base = c.addr - (c.addr % tot);
      return base + ((c.addr - base + ii * bytes) % tot);
    end
    return c.addr + ii * bytes;
  endfunction

  function automatic cmd_t mk(input logic [AW-1:0] a, input int len, input int size,
                              input int burst, input logic typ);
    cmd_t c;
    c.addr = a; c.len = 8'(len); c.size = 3'(size); c.burst = 2'(burst); c.typ = typ;
    return c;
  endfunction

  function automatic bit next_ready();
    if (rdy_script.size() != 0) return rdy_script.pop_front();
    if (rdy_mode == 0) return 1'b1;
    return ($urandom_range(0, 3) != 0);
  endfunction

  // Monitor / reference model, evaluated mid-cycle when everything is settled.
  cmd_t  mon_c;
  beat_t mon_h, mon_b;
  logic  mon_rdy, mon_acc;
  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_valid",  bus.beat_valid,  0);
      chk("rst_aready", bus.paxi_aready, 0);
      chk("rst_addr",   bus.beat_addr,   0);
      chk("rst_idx",    bus.beat_idx,    0);
      chk("rst_last",   bus.beat_last,   0);
      chk("rst_type",   bus.beat_type,   0);
      chk("rst_err",    bus.burst_err,   0);
      exp_q.delete();
      err_pend = 1'b0;
    end else begin
      mon_rdy = (exp_q.size() == 0) || (bus.beat_ready && exp_q.size() == 1);
      chk("valid",  bus.beat_valid,  exp_q.size() != 0);
      chk("aready", bus.paxi_aready, mon_rdy);
      chk("err",    bus.burst_err,   err_pend);
      if (exp_q.size() != 0) begin
        mon_h = exp_q[0];
        chk("addr", bus.beat_addr, mon_h.addr);
        chk("idx",  bus.beat_idx,  mon_h.idx);
        chk("last", bus.beat_last, mon_h.last);
        chk("type", bus.beat_type, mon_h.typ);
        if (bus.beat_ready) void'(exp_q.pop_front());
      end
      mon_acc  = bus.paxi_avalid && mon_rdy;
      err_pend = 1'b0;
      if (mon_acc) begin
        mon_c.addr = bus.paxi_aaddr; mon_c.len = bus.paxi_alen; mon_c.size = bus.paxi_asize;
        mon_c.burst = bus.paxi_aburst; mon_c.typ = bus.paxi_atype;
        err_pend = illegal_cmd(mon_c);
        for (int i = 0; i <= int'(mon_c.len); i++) begin
          mon_b.addr = addr_of(mon_c, i);
          mon_b.idx  = 8'(i);
          mon_b.last = (i == int'(mon_c.len));
          mon_b.typ  = mon_c.typ;
          exp_q.push_back(mon_b);
        end
      end
    end
  end

  task automatic idle(input int n);
    bus.paxi_avalid = 1'b0;
    repeat (n) begin
      bus.beat_ready = next_ready();
      @(posedge clk); #1;
    end
  endtask

  // Present a command and hold it until the handshake edge has passed.
  task automatic send(input cmd_t c);
    bit acc;
    acc = 1'b0;
    bus.paxi_aaddr = c.addr; bus.paxi_alen = c.len; bus.paxi_asize = c.size;
    bus.paxi_aburst = c.burst; bus.paxi_atype = c.typ; bus.paxi_avalid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      bus.beat_ready = next_ready();
      @(negedge clk);
      if (bus.paxi_aready) begin
        acc = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    bus.paxi_avalid = 1'b0;
  endtask

  initial begin
    cmd_t c;
    n_chk = 0; n_fail = 0; rdy_mode = 0; err_pend = 1'b0;
    rstn = 1'b0;
    bus.paxi_avalid = 1'b0; bus.paxi_aaddr = '0; bus.paxi_alen = '0; bus.paxi_asize = '0;
    bus.paxi_aburst = '0; bus.paxi_atype = 1'b0; bus.beat_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    #1 chk("aready_after_rst", bus.paxi_aready, 1);

    send(mk(32'h1000, 3, 2, 1, ATYPE_READ));   idle(6);
    send(mk(32'h2034, 3, 2, 2, ATYPE_WRITE));  idle(6);
    rdy_script = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    send(mk(32'h0040, 2, 2, 0, ATYPE_READ));   idle(8);
    send(mk(32'h0500, 0, 3, 1, ATYPE_READ));
    send(mk(32'h0600, 1, 3, 1, ATYPE_WRITE));  idle(4);
    send(mk(32'h3000, 2, 2, 2, ATYPE_READ));   idle(5);
    send(mk(32'h4000, 1, 1, 3, ATYPE_WRITE));  idle(4);
    send(mk(32'hFFFF_FFF8, 3, 2, 1, ATYPE_READ)); idle(6);

    // Reset in the middle of a long burst.
    send(mk(32'h5000, 7, 2, 1, ATYPE_WRITE));
    @(posedge clk); #3;
    rstn = 1'b0;
    #1 chk("async_rst_valid", bus.beat_valid, 0);
    chk("async_rst_aready", bus.paxi_aready, 0);
    @(posedge clk); #1 rstn = 1'b1;
    #1 chk("post_rst_aready", bus.paxi_aready, 1);
    idle(4);

    rdy_mode = 1;
    for (int n = 0; n < 60; n++) begin
      c.burst = 2'($urandom_range(0, 3));
      if (c.burst == 2'b10 && $urandom_range(0, 3) != 0)
        c.len = 8'((1 << $urandom_range(1, 4)) - 1);
      else
        c.len = 8'($urandom_range(0, 15));
      c.size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
      c.addr = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255))) : $urandom;
      c.typ  = 1'($urandom_range(0, 1));
      send(c);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    rdy_mode = 0;
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) idle(1);
    chk("drain", exp_q.size(), 0);
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/paxi_beat_gen.md
# paxi_beat_gen

Beat generator directly downstream of the AW/AR merger. Consumes one merged packed-AXI address command (address, len, size, burst, type) per handshake and expands it into one per-beat command carrying the computed beat address, beat index and last flag for the memory-side datapath. Supports FIXED, INCR and WRAP bursts, with back-to-back commands and no bubble cycles.

## Interface
- ADDR_WIDTH, 32, address width of the input command and the beat address.
- clk  in  1  single clock; all logic on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- paxi_aaddr  in  ADDR_WIDTH  burst start address.
- paxi_alen  in  8  beats minus one.
- paxi_asize  in  3  log2(bytes per beat).
- paxi_aburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- paxi_atype  in  1  1 = write, 0 = read.
- paxi_avalid  in  1  command valid.
- paxi_aready  out  1  command accepted when high with avalid.
- beat_addr  out  ADDR_WIDTH  address of the current beat.
- beat_type  out  1  atype of the owning burst.
- beat_idx  out  8  beat number, 0..alen.
- beat_last  out  1  high on beat idx == alen.
- beat_valid  out  1  beat command valid.
- beat_ready  in  1  beat consumed when high with beat_valid.
- burst_err  out  1  one-cycle pulse on acceptance of an illegal command.

## Operation
- Internal state: a command register (start address, len, size, effective burst, type) plus a current address and a beat counter. busy = beat_valid.
- paxi_aready = rstn & (~beat_valid | (beat_ready & beat_last)). A new command loads on the same edge that retires the previous last beat.
- On accept: beat_addr <= aaddr, beat_idx <= 0, beat_last <= (alen == 0), beat_type <= atype, beat_valid <= 1.
- On beat handshake when the beat is not last: beat_idx increments, beat_addr <= next address, beat_last <= (beat_idx + 1 == len).
- On last-beat handshake without a new command: beat_valid <= 0.
- Next address, with bytes = 1 << asize and arithmetic modulo 2^ADDR_WIDTH:
  - FIXED: address unchanged.
  - INCR: addr + bytes. No 4 KB boundary check; upstream owns that.
  - WRAP: tot = bytes * (len + 1); next = (addr & ~(tot - 1)) | ((addr + bytes) & (tot - 1)).
- Illegal commands: WRAP with len not in {1, 3, 7, 15}, or aburst = 11. Both execute as INCR and pulse burst_err on the accept cycle.
- asize is not range-checked. Bytes is computed at ADDR_WIDTH width.
- While beat_valid & ~beat_ready, all beat_* outputs hold stable.

## Timing
- Reset values: beat_valid 0, beat_addr 0, beat_idx 0, beat_last 0, beat_type 0, burst_err 0, paxi_aready 0 while rstn is low. paxi_aready rises combinationally once rstn is released.
- Latency: the first beat is valid the cycle after the command handshake.
- Throughput: with beat_ready held high, alen+1 beats appear on consecutive cycles. The next command's beat 0 follows the previous last beat with zero gap.
- Reset asserted mid-burst: the remaining beats are discarded immediately and there is no residual output after release.
- paxi_aready depends combinationally on beat_ready. No combinational path exists from paxi_avalid to any output.

## Structure
- Shared package paxi_pkg holds:
  - burst encoding enum: BURST_FIXED, BURST_INCR, BURST_WRAP, BURST_RSVD;
  - ATYPE_WRITE = 1 and ATYPE_READ = 0.
- One combinational sub-module, paxi_next_addr, maps (addr, size, len, burst) to next_addr. It is reusable by the write-data path.

## Test plan
- INCR, addr 0x1000, len 3, size 2, ready held high: beats at 0x1000, 0x1004, 0x1008, 0x100C on 4 consecutive cycles; last only on idx 3.
- WRAP, addr 0x2034, len 3, size 2: beats at 0x2034, 0x2038, 0x203C, 0x2030.
- FIXED, addr 0x40, len 2, with beat_ready low on the 2nd beat for 3 cycles: addr 0x40 on all 3 beats; outputs stable during the stall.
- Back-to-back commands (read len 0, then write len 1, avalid held): beats arrive on 3 consecutive cycles with no gap; type sequence 0, 1, 1.
- WRAP with len 2: burst_err pulses for 1 cycle; beats at addr, +bytes, +2·bytes as INCR.
- rstn pulled low during beat 1 of a len 7 burst: beat_valid drops asynchronously; after release paxi_aready = 1 and no stale beats appear.
